// File: rtl/packet_fifo.sv
// Single-clock FIFO with packet commit/rollback: written words stay hidden from
// the reader until committed, and an uncommitted frame can be discarded.
module packet_fifo #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 64,
  parameter int ALMOST_FULL  = 4,
  parameter int ALMOST_EMPTY = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_commit,
  input  logic                     wr_rollback,
  output logic [$clog2(DEPTH):0]   wr_size,
  output logic                     wr_full,
  output logic                     wr_almost_full,
  output logic                     wr_overflow,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   rd_size,
  output logic                     rd_empty,
  output logic                     rd_almost_empty,
  output logic                     rd_underflow
);

  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int PW        = ADDR_BITS + 1;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_P    = PW'(ALMOST_FULL);
  localparam logic [PW-1:0] AE_P    = PW'(ALMOST_EMPTY);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_commitPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [WIDTH-1:0] r_rdData;
  logic             r_rdValid;
  logic             r_wrOverflow;
  logic             r_rdUnderflow;

  logic [PW-1:0]    w_used;
  logic [PW-1:0]    w_wrSize;
  logic [PW-1:0]    w_rdSize;
  logic             w_full;
  logic             w_empty;
  logic             w_wrAccept;
  logic             w_wrReject;
  logic             w_rdAccept;
  logic [PW-1:0]    w_wrPtrNext;

  // Occupancy is derived purely from registered pointers; flags follow from it.
  always_comb begin
    w_used   = r_wrPtr - r_rdPtr;
    w_wrSize = DEPTH_P - w_used;
    w_rdSize = r_commitPtr - r_rdPtr;
    w_full   = (w_wrSize == '0);
    w_empty  = (w_rdSize == '0);
  end

  // A rollback silently drops a same-cycle write, so it never counts as overflow.
  always_comb begin
    w_wrAccept  = wr_en && !w_full && !wr_rollback;
    w_wrReject  = wr_en && w_full && !wr_rollback;
    w_rdAccept  = rd_en && !w_empty;
    w_wrPtrNext = r_wrPtr + {{ADDR_BITS{1'b0}}, w_wrAccept};
  end

  always_ff @(posedge clk) begin
    if (w_wrAccept) begin
      r_mem[r_wrPtr[ADDR_BITS-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_commitPtr <= '0;
    end else if (wr_rollback) begin
      r_wrPtr <= r_commitPtr;
    end else begin
      r_wrPtr <= w_wrPtrNext;
      if (wr_commit) begin
        r_commitPtr <= w_wrPtrNext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr       <= '0;
      r_rdData      <= '0;
      r_rdValid     <= 1'b0;
      r_wrOverflow  <= 1'b0;
      r_rdUnderflow <= 1'b0;
    end else begin
      r_rdValid     <= w_rdAccept;
      r_wrOverflow  <= w_wrReject;
      r_rdUnderflow <= rd_en && w_empty;
      if (w_rdAccept) begin
        r_rdData <= r_mem[r_rdPtr[ADDR_BITS-1:0]];
        r_rdPtr  <= r_rdPtr + 1'b1;
      end
    end
  end

  assign wr_size         = w_wrSize;
  assign wr_full         = w_full;
  assign wr_almost_full  = (w_wrSize <= AF_P);
  assign wr_overflow     = r_wrOverflow;
  assign rd_data         = r_rdData;
  assign rd_valid        = r_rdValid;
  assign rd_size         = w_rdSize;
  assign rd_empty        = w_empty;
  assign rd_almost_empty = (w_rdSize <= AE_P);
  assign rd_underflow    = r_rdUnderflow;

endmodule

// File: tb/tb_packet_fifo.sv
// Directed bench for packet_fifo (DEPTH=8, ALMOST_FULL=2, ALMOST_EMPTY=1):
// a vector table for the basic frames plus hand-written full/wrap/reset sequences.
module tb_packet_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 2;
  localparam int AE    = 1;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             wr_commit;
  logic             wr_rollback;
  logic [3:0]       wr_size;
  logic             wr_full;
  logic             wr_almost_full;
  logic             wr_overflow;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [3:0]       rd_size;
  logic             rd_empty;
  logic             rd_almost_empty;
  logic             rd_underflow;

  int passCount  = 0;
  int totalCount = 0;

  typedef struct {
    logic        wrEn;
    logic [31:0] wrData;
    logic        commit;
    logic        rollback;
    logic        rdEn;
    int          expWrSize;
    int          expRdSize;
    logic        expOvf;
    logic        expUnf;
    logic        expValid;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[23];

  packet_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit), .wr_rollback(wr_rollback),
    .wr_size(wr_size), .wr_full(wr_full), .wr_almost_full(wr_almost_full),
    .wr_overflow(wr_overflow),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_size(rd_size),
    .rd_empty(rd_empty), .rd_almost_empty(rd_almost_empty), .rd_underflow(rd_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs, samples 1ns after the edge, then idles the inputs.
  task automatic applyStimulus(input logic wrEn, input logic [31:0] wrData,
                               input logic commit, input logic rollback, input logic rdEn);
    wr_en       = wrEn;
    wr_data     = wrData;
    wr_commit   = commit;
    wr_rollback = rollback;
    rd_en       = rdEn;
    @(posedge clk);
    #1;
    wr_en       = 1'b0;
    wr_data     = '0;
    wr_commit   = 1'b0;
    wr_rollback = 1'b0;
    rd_en       = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passCount++;
  endtask

  task automatic checkAll(input string tag, input int eWr, input int eRd, input logic eOvf,
                          input logic eUnf, input logic eValid, input logic [31:0] eData);
    checkOutput({tag, ".wr_size"}, 32'(wr_size), eWr);
    checkOutput({tag, ".rd_size"}, 32'(rd_size), eRd);
    checkOutput({tag, ".wr_full"}, 32'(wr_full), 32'(eWr == 0));
    checkOutput({tag, ".wr_almost_full"}, 32'(wr_almost_full), 32'(eWr <= AF));
    checkOutput({tag, ".rd_empty"}, 32'(rd_empty), 32'(eRd == 0));
    checkOutput({tag, ".rd_almost_empty"}, 32'(rd_almost_empty), 32'(eRd <= AE));
    checkOutput({tag, ".wr_overflow"}, 32'(wr_overflow), 32'(eOvf));
    checkOutput({tag, ".rd_underflow"}, 32'(rd_underflow), 32'(eUnf));
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(eValid));
    checkOutput({tag, ".rd_data"}, rd_data, eData);
  endtask

  initial begin
    logic [31:0] lastData;

    //          wrEn  wrData     cmt   rb    rdEn  wrSz rdSz ovf   unf   vld   data
    vecs[0]  = '{1'b1, 32'hA1,   1'b0, 1'b0, 1'b0, 7,   0,   1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'hA2,   1'b0, 1'b0, 1'b0, 6,   0,   1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'hA3,   1'b0, 1'b0, 1'b0, 5,   0,   1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 5,   3,   1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 6,   2,   1'b0, 1'b0, 1'b1, 32'hA1};
    vecs[5]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 7,   1,   1'b0, 1'b0, 1'b1, 32'hA2};
    vecs[6]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 8,   0,   1'b0, 1'b0, 1'b1, 32'hA3};
    vecs[7]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 8,   0,   1'b0, 1'b1, 1'b0, 32'hA3};
    vecs[8]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 8,   0,   1'b0, 1'b0, 1'b0, 32'hA3};
    vecs[9]  = '{1'b1, 32'h0A,   1'b0, 1'b0, 1'b0, 7,   0,   1'b0, 1'b0, 1'b0, 32'hA3};
    vecs[10] = '{1'b1, 32'h0B,   1'b1, 1'b0, 1'b0, 6,   2,   1'b0, 1'b0, 1'b0, 32'hA3};
    vecs[11] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 7,   1,   1'b0, 1'b0, 1'b1, 32'h0A};
    vecs[12] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 8,   0,   1'b0, 1'b0, 1'b1, 32'h0B};
    vecs[13] = '{1'b1, 32'h11,   1'b0, 1'b0, 1'b0, 7,   0,   1'b0, 1'b0, 1'b0, 32'h0B};
    vecs[14] = '{1'b1, 32'h12,   1'b1, 1'b0, 1'b0, 6,   2,   1'b0, 1'b0, 1'b0, 32'h0B};
    vecs[15] = '{1'b1, 32'h21,   1'b0, 1'b0, 1'b0, 5,   2,   1'b0, 1'b0, 1'b0, 32'h0B};
    vecs[16] = '{1'b1, 32'h22,   1'b0, 1'b0, 1'b0, 4,   2,   1'b0, 1'b0, 1'b0, 32'h0B};
    vecs[17] = '{1'b1, 32'h23,   1'b0, 1'b0, 1'b0, 3,   2,   1'b0, 1'b0, 1'b0, 32'h0B};
    vecs[18] = '{1'b1, 32'h24,   1'b0, 1'b0, 1'b0, 2,   2,   1'b0, 1'b0, 1'b0, 32'h0B};
    vecs[19] = '{1'b1, 32'h99,   1'b1, 1'b1, 1'b0, 6,   2,   1'b0, 1'b0, 1'b0, 32'h0B};
    vecs[20] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 7,   1,   1'b0, 1'b0, 1'b1, 32'h11};
    vecs[21] = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 8,   0,   1'b0, 1'b0, 1'b1, 32'h12};
    vecs[22] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 8,   0,   1'b0, 1'b0, 1'b0, 32'h12};

    rst_n = 1'b0;
    wr_en = 1'b0; wr_data = '0; wr_commit = 1'b0; wr_rollback = 1'b0; rd_en = 1'b0;
    #12;
    checkAll("reset", 8, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].wrEn, vecs[i].wrData, vecs[i].commit, vecs[i].rollback, vecs[i].rdEn);
      checkAll($sformatf("vec%0d", i), vecs[i].expWrSize, vecs[i].expRdSize, vecs[i].expOvf,
               vecs[i].expUnf, vecs[i].expValid, vecs[i].expData);
    end

    // Fill to capacity, then push against the full FIFO.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'hD0 + i, (i == 7), 1'b0, 1'b0);
      checkAll($sformatf("fill%0d", i), 7 - i, (i == 7) ? 8 : 0, 1'b0, 1'b0, 1'b0, 32'h12);
    end
    applyStimulus(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0);
    checkAll("overflow", 0, 8, 1'b1, 1'b0, 1'b0, 32'h12);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkAll("overflowEnd", 0, 8, 1'b0, 1'b0, 1'b0, 32'h12);
    applyStimulus(1'b1, 32'hFF, 1'b0, 1'b0, 1'b1);
    checkAll("fullRdWr", 1, 7, 1'b1, 1'b0, 1'b1, 32'hD0);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      checkAll($sformatf("drain%0d", i), 1 + i, 7 - i, 1'b0, 1'b0, 1'b1, 32'hD0 + i);
    end

    // Streaming write+commit with a read one word behind, wrapping the pointers.
    lastData = 32'hD7;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'h100 + i, 1'b1, 1'b0, (i > 0));
      if (i > 0) lastData = 32'h100 + i - 1;
      checkAll($sformatf("wrap%0d", i), 7, 1, 1'b0, 1'b0, (i > 0), lastData);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkAll("wrapLast", 8, 0, 1'b0, 1'b0, 1'b1, 32'h113);

    // Asynchronous reset in the middle of an uncommitted frame.
    applyStimulus(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h32, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h34, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h35, 1'b0, 1'b0, 1'b1);
    checkAll("preReset", 4, 1, 1'b0, 1'b0, 1'b1, 32'h31);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("asyncReset", 8, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkAll("postReset", 8, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h41, 1'b1, 1'b0, 1'b0);
    checkAll("newWrite", 7, 1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkAll("newRead", 8, 0, 1'b0, 1'b0, 1'b1, 32'h41);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
